// File: rtl/pin_period_meter_pkg.sv
// Shared types and default constants for the pin period meter and its debouncer.
package pin_period_meter_pkg;

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned TIMEOUT_DEF         = 100000000;

endpackage

// File: rtl/pin_debounce.sv
// Synchroniser plus debouncer for one asynchronous input pin; emits the clean level
// and a one-cycle pulse on every accepted level change.
module pin_debounce
  import pin_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic level,
  output logic edge_pulse
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        db_cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Any cycle agreeing with the current level restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= 1'b0;
      db_cnt     <= '0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (s != level) begin
        if (db_cnt == DB_LAST) begin
          level      <= ~level;
          db_cnt     <= '0;
          edge_pulse <= 1'b1;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pin_period_meter.sv
// Measures clk cycles between successive debounced pin edges and offers each
// interval on a valid/ready interface, with overrun flag and timeout pulse.
module pin_period_meter
  import pin_period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned TIMEOUT         = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin_in,
  output logic             level,
  output logic             edge_pulse,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_level,
  output logic             meas_overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             timeout_hit;
  logic             transfer;

  pin_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_in    (pin_in),
    .level     (level),
    .edge_pulse(edge_pulse)
  );

  // Loaded with 1 on an edge so that pulses N cycles apart read N at the second one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= CNT_W'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FIRST: if (edge_pulse) state_d = MEASURE;
      MEASURE:    if (!edge_pulse && cnt == TIMEOUT_VAL) state_d = WAIT_FIRST;
      default:    state_d = WAIT_FIRST;
    endcase
  end

  always_comb begin
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (state_q == MEASURE) begin
      if (edge_pulse) begin
        capture = 1'b1;
      end else if (cnt == TIMEOUT_VAL) begin
        timeout_hit = 1'b1;
      end
    end
  end

  assign transfer = meas_valid && meas_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_hit;
    end
  end

  // A capture coinciding with a transfer replaces a word that has already left, so no overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid   <= 1'b0;
      meas_period  <= '0;
      meas_level   <= 1'b0;
      meas_overrun <= 1'b0;
    end else if (capture) begin
      meas_valid   <= 1'b1;
      meas_period  <= cnt;
      meas_level   <= level;
      meas_overrun <= meas_valid && !meas_ready;
    end else if (transfer) begin
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pin_period_meter.sv
// Randomised scoreboard bench for pin_period_meter: expected words come from pin change
// spacing, a negedge monitor pops and compares on every handshake.
module tb_pin_period_meter;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TIMEOUT         = 1000;

  typedef struct {
    int unsigned period;
    logic        lvl;
    logic        ovr;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pin_in;
  logic             level;
  logic             edge_pulse;
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_period;
  logic             meas_level;
  logic             meas_overrun;
  logic             timeout;

  pin_period_meter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pin_in      (pin_in),
    .level       (level),
    .edge_pulse  (edge_pulse),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_period (meas_period),
    .meas_level  (meas_level),
    .meas_overrun(meas_overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  word_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  bit          armed = 0;
  bit          hold = 0;
  bit          pend_valid = 0;
  word_t       pend;
  bit          rdy_rand = 0;
  int          exp_timeouts = 0;
  int          got_timeouts = 0;
  int          got_edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rdy_rand) meas_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic seg(input int unsigned d);
    repeat (d) tick();
  endtask

  // Model: a lasting pin change becomes a debounced edge after a fixed latency, so the
  // measured interval is just the spacing of pin changes; gaps beyond TIMEOUT disarm.
  task automatic change(input logic v);
    int unsigned d;
    word_t       w;
    d        = cyc - last_cyc;
    last_cyc = cyc;
    pin_in   = v;
    if (armed && d > TIMEOUT) begin
      exp_timeouts++;
      armed = 0;
    end
    if (armed) begin
      w = '{period: d, lvl: v, ovr: 1'b0};
      if (hold) begin
        if (pend_valid) w.ovr = 1'b1;
        pend       = w;
        pend_valid = 1;
      end else begin
        exp_q.push_back(w);
      end
    end
    armed = 1;
  endtask

  // Segment with a sub-debounce glitch well away from both of its ends.
  task automatic rand_seg(input int unsigned d);
    int unsigned pre, g;
    pre = $urandom_range(20, d - 25);
    g   = $urandom_range(1, DEBOUNCE_CYCLES - 1);
    seg(pre);
    pin_in = ~pin_in;
    seg(g);
    pin_in = ~pin_in;
    seg(d - pre - g);
  endtask

  always @(negedge clk) begin
    word_t w;
    if (rst_n) begin
      if (timeout) got_timeouts++;
      if (edge_pulse) got_edges++;
      if (meas_valid && meas_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got period %0d, required no word", meas_period);
        end else begin
          w = exp_q.pop_front();
          check("meas_period", 32'(meas_period), w.period);
          check("meas_level", 32'(meas_level), 32'(w.lvl));
          check("meas_overrun", 32'(meas_overrun), 32'(w.ovr));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of stimulus, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tmo0;
    rst_n      = 1'b0;
    pin_in     = 1'b0;
    meas_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("level_after_reset", 32'(level), 0);
    check("valid_after_reset", 32'(meas_valid), 0);

    // glitch of DEBOUNCE_CYCLES-1 cycles is rejected
    seg(10);
    pin_in = 1'b1;
    seg(DEBOUNCE_CYCLES - 1);
    pin_in = 1'b0;
    seg(20);
    check("glitch_level", 32'(level), 0);
    check("glitch_edges", 32'(got_edges), 0);
    last_cyc = cyc;

    // square wave, half-period 100, always ready
    meas_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      change(~pin_in);
      seg(100);
    end
    check("square_drained", 32'(exp_q.size()), 0);

    // random half-periods, glitches and random ready
    rdy_rand = 1;
    for (int i = 0; i < 20; i++) begin
      change(~pin_in);
      rand_seg($urandom_range(40, 150));
    end

    // backpressure across two edges
    rdy_rand   = 0;
    meas_ready = 1'b1;
    seg(10);
    meas_ready = 1'b0;
    hold       = 1;
    change(~pin_in);
    seg(100);
    change(~pin_in);
    seg(100);
    check("bp_valid_held", 32'(meas_valid), 1);
    check("bp_overrun_flag", 32'(meas_overrun), 1);
    exp_q.push_back(pend);
    pend_valid = 0;
    hold       = 0;
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    seg(3);
    check("bp_valid_after_one", 32'(meas_valid), 0);
    meas_ready = 1'b1;

    // timeout then re-arm
    change(~pin_in);
    tmo0 = got_timeouts;
    seg(1200);
    check("timeout_pulses", 32'(got_timeouts - tmo0), 1);
    change(~pin_in);
    seg(100);
    change(~pin_in);
    seg(100);

    // interval exactly TIMEOUT: the edge wins
    change(~pin_in);
    seg(TIMEOUT);
    change(~pin_in);
    seg(100);
    check("timeout_count", 32'(got_timeouts), 32'(exp_timeouts));

    // reset while a word is pending
    meas_ready = 1'b0;
    hold       = 1;
    if (pin_in) begin
      change(1'b0);
      seg(60);
    end else begin
      change(1'b1);
      seg(60);
      change(1'b0);
      seg(60);
    end
    check("pre_reset_valid", 32'(meas_valid), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_meas_period", 32'(meas_period), 0);
    check("rst_meas_level", 32'(meas_level), 0);
    check("rst_meas_overrun", 32'(meas_overrun), 0);
    check("rst_level", 32'(level), 0);
    check("rst_edge_pulse", 32'(edge_pulse), 0);
    check("rst_timeout", 32'(timeout), 0);
    hold       = 0;
    pend_valid = 0;
    armed      = 0;
    seg(2);
    rst_n    = 1'b1;
    rdy_rand = 1;
    seg(20);
    change(1'b1);
    seg(80);
    change(1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_seg($urandom_range(40, 150));
      change(~pin_in);
    end
    seg(200);

    check("final_drained", 32'(exp_q.size()), 0);
    check("final_timeouts", 32'(got_timeouts), 32'(exp_timeouts));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_period_meter.md
Name: pin_period_meter

Overview:
- Input-side counterpart to the board's free-running LED/pin toggler: samples an asynchronous toggling pin, debounces it, and measures the interval between successive debounced edges in clk cycles.
- Each measurement goes out on a valid/ready interface, for use by a status block or a virtual-wire probe.
- Sits directly behind a board input pin. Loopback of pin_77 into this block is the board-level self-test.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count (≥2).
- DEBOUNCE_CYCLES, 16: consecutive mismatching cycles required to accept a level change (≥1).
- CNT_W, 32: width of the interval counter and of meas_period.
- TIMEOUT, 100000000: interval counter value at which measurement is abandoned (< 2^CNT_W − 1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pin_in  in  1  raw asynchronous pin.
- level  out  1  debounced pin level.
- edge_pulse  out  1  one-cycle pulse on every debounced level change.
- meas_valid  out  1  measurement available.
- meas_ready  in  1  consumer accepts the measurement when high with meas_valid.
- meas_period  out  CNT_W  clk cycles between the last two debounced edges.
- meas_level  out  1  debounced level after the edge that closed the interval.
- meas_overrun  out  1  set in the payload when an unaccepted measurement was overwritten.
- timeout  out  1  one-cycle pulse when TIMEOUT is reached without an edge.

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops, level, debounce counter, interval counter, edge_pulse, meas_valid, meas_period, meas_level, meas_overrun and timeout are 0.
  - FSM goes to WAIT_FIRST.
- Synchroniser: SYNC_STAGES flop chain; the last stage is `s`.
- Debounce:
  - db_cnt increments each cycle that s ≠ level, and clears on any cycle that s == level.
  - When s ≠ level and db_cnt == DEBOUNCE_CYCLES−1, level toggles and db_cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level.
  - Latency from a stable pin_in change to level: SYNC_STAGES+DEBOUNCE_CYCLES cycles (±1 for sampling phase).
- edge_pulse: registered, high for the single cycle after level toggles.
- Interval counter (cnt):
  - On an edge_pulse cycle, cnt is loaded with 1.
  - Otherwise cnt increments, saturating at all-ones.
  - Consequence: edge pulses N cycles apart yield cnt == N at the second pulse.
- FSM:
  - WAIT_FIRST: edge_pulse → MEASURE. No measurement is produced.
  - MEASURE, edge_pulse: capture cnt into meas_period and the current level into meas_level; stay in MEASURE.
  - MEASURE, cnt == TIMEOUT with no edge this cycle: timeout pulses for 1 cycle; go to WAIT_FIRST.
  - MEASURE, edge_pulse and cnt == TIMEOUT in the same cycle: the edge wins (capture, no timeout).
- Output handshake:
  - Transfer happens when meas_valid && meas_ready.
  - meas_valid rises the cycle after the capturing edge_pulse and holds until transferred.
  - meas_period, meas_level and meas_overrun are stable while meas_valid && !meas_ready.
  - Capture while meas_valid && !meas_ready: payload is overwritten with new data, meas_overrun = 1, meas_valid stays 1.
  - Capture in the same cycle as a transfer: old word is transferred, new word loads with meas_overrun = 0, meas_valid stays 1.
  - Capture while !meas_valid: meas_overrun = 0.
- Reset mid-operation aborts any pending measurement; meas_valid drops immediately.

Decomposition:
- Shared package: FSM state enum {WAIT_FIRST, MEASURE} and default constants DEBOUNCE_CYCLES_DEF and TIMEOUT_DEF.
- One sub-module, pin_debounce: synchroniser plus debounce, producing level and edge_pulse. It is reusable for the board's other input pins.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=16, TIMEOUT=1000):
- Reset values: assert rst_n=0 mid-clock → all outputs 0 asynchronously. Release with pin_in=0 → level=0, meas_valid=0.
- Glitch rejection: pin_in high for 3 cycles then low → level stays 0, no edge_pulse, no measurement.
- Square-wave measurement: pin_in square wave with 100-cycle half-period, meas_ready=1.
  - First edge produces no word.
  - Each later edge produces meas_period=100, with meas_level alternating 0/1 and meas_overrun=0.
- Backpressure: meas_ready=0 across two edges → payload is the latest word (100) with meas_overrun=1. Raise meas_ready → one transfer, then meas_valid=0.
- Timeout: after an edge, hold pin_in for 1200 cycles.
  - timeout pulses exactly once, when cnt reaches 1000.
  - The next edge produces no word; the edge after it gives the correct period.
- Reset mid-operation: pulse rst_n low while meas_valid=1 and in MEASURE → meas_valid=0 immediately. After release the first edge yields no measurement.
